stack_tos_cache: RTL and testbench
==================================

// Module: stack_tos_cache
// PURPOSE
//   Parametrised data/return stack for the Forth core: top-of-stack (TOS) held in a register,
//   next-on-stack (NOS) delivered from synchronous RAM, one push/pop/replace per cycle.
//   Adds depth tracking, full/empty status and sticky overflow/underflow flags.
//   Sits between the CPU datapath and the stack RAM; one instance each for data and return stacks.
// PARAMETERS
//   ADDR_W    8   RAM address width; capacity CAP = 2**ADDR_W + 1 (TOS reg + RAM entries)
//   WIDTH     16  data word width
//   OVF_MODE  0   0 = WRAP (push when full overwrites oldest), 1 = REJECT (push when full ignored)
// PORTS
//   clk       in   1         clock, all state on rising edge
//   reset_n   in   1         asynchronous reset, active-low
//   push      in   1         push d
//   pop       in   1         pop one entry
//   wr_tos    in   1         overwrite TOS with d
//   d         in   WIDTH     write data
//   err_clr   in   1         clear overflow/underflow flags
//   tos       out  WIDTH     top entry, registered
//   nos       out  WIDTH     second entry, registered
//   depth     out  ADDR_W+1  entries held, 0..CAP (CAP needs ADDR_W+1 bits; saturates at CAP)
//   empty     out  1         depth == 0
//   full      out  1         depth == CAP
//   overflow  out  1         sticky: push while full (pop not asserted)
//   underflow out  1         sticky: pop while empty (push not asserted)
// BEHAVIOUR
//   Reset (async, reset_n=0): sp=0, depth=0, tos=0, nos=0, overflow=0, underflow=0. RAM not cleared.
//     Reset mid-operation discards the in-flight op; first op after release sees an empty stack.
//   RAM holds depth-1 entries; sp addresses the NOS slot. nos = registered RAM read at next sp.
//   Op decode, priority top-down, result visible on tos/nos/depth the cycle after the edge:
//     push & pop          -> replace: tos<=d, sp/depth/nos unchanged
//     push                -> depth 0: tos<=d, depth=1, no RAM write, sp unchanged
//                            depth>=1: RAM[sp+1]<=tos, nos<=tos (forwarded), tos<=d, sp+=1, depth+=1
//     pop & wr_tos        -> binary-op collapse: tos<=d, sp-=1, depth-=1, nos<=RAM[sp-1]
//     pop                 -> tos<=nos, sp-=1, depth-=1, nos<=RAM[sp-1]
//     wr_tos              -> tos<=d only
//     none                -> hold
//   sp arithmetic is modulo 2**ADDR_W; no pointer move when depth transitions 0<->1.
//   Pop to depth 0: tos<=0. nos is don't-care while depth<2.
//   Overflow (push, !pop, full): set overflow.
//     WRAP: push proceeds, sp wraps, depth stays CAP, oldest entry lost.
//     REJECT: all state unchanged.
//   Underflow (pop, !push, empty): set underflow, all state unchanged (wr_tos also ignored).
//   Replace while empty: tos<=d, depth becomes 1; no flag set.
//   Flags: set has priority over err_clr in the same cycle; otherwise err_clr clears both.
//   RAM read-during-write to same address: write data forwarded to nos.
// STRUCTURE
//   Shared package/header stack_pkg: OVF_WRAP=0, OVF_REJECT=1 constants; op-decode localparams.
//   Sub-module stack_ptr: sp and depth counters, full/empty, next-sp computation (successor of sp_comb).
//   RAM inferred as 2**ADDR_W x WIDTH, one write + one synchronous read port.
// TESTING
//   1. reset_n=0 pulse mid-push -> depth=0, tos=0, empty=1, flags 0 asynchronously.
//   2. push 0x1111,0x2222,0x3333 -> tos=0x3333, nos=0x2222, depth=3; pop -> tos=0x2222, nos=0x1111, depth=2.
//   3. depth=2, pop+wr_tos d=0x00AA -> tos=0x00AA, depth=1; then pop -> depth=0, tos=0, empty=1.
//   4. ADDR_W=2, OVF_MODE=0: push 1..6 -> overflow=1, depth=5, tos=6, nos=5; 4 pops reach value 2.
//   5. ADDR_W=2, OVF_MODE=1: push 1..6 -> overflow=1, depth=5, tos=5; err_clr -> overflow=0.
//   6. empty, pop -> underflow=1, depth=0; push+pop d=0x7 same cycle -> tos=7, depth=1, no flag.

Source files
------------

// File: rtl/stack_tos_cache_pkg.sv
// Shared constants and op decode for the TOS-cached stack.
package stack_tos_cache_pkg;

  localparam bit OVF_WRAP   = 1'b0;
  localparam bit OVF_REJECT = 1'b1;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_REPL,
    OP_PUSH,
    OP_POPWR,
    OP_POP,
    OP_WR
  } op_e;

  // Priority order matters: push+pop is a replace, pop+wr_tos is a binary-op collapse.
  function automatic op_e decode_op(input logic push, input logic pop, input logic wr);
    if (push && pop) return OP_REPL;
    if (push)        return OP_PUSH;
    if (pop && wr)   return OP_POPWR;
    if (pop)         return OP_POP;
    if (wr)          return OP_WR;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_tos_cache_if.sv
// CPU-side port bundle of one stack instance (data or return stack).
interface stack_tos_cache_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
);
  logic              push;
  logic              pop;
  logic              wr_tos;
  logic [WIDTH-1:0]  d;
  logic              err_clr;
  logic [WIDTH-1:0]  tos;
  logic [WIDTH-1:0]  nos;
  logic [ADDR_W:0]   depth;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, wr_tos, d, err_clr,
    input  tos, nos, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, wr_tos, d, err_clr,
    output tos, nos, depth, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_tos_cache_ptr.sv
// Stack pointer (NOS slot address) and depth counter with full/empty status.
module stack_tos_cache_ptr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sp_inc_i,
  input  logic              sp_dec_i,
  input  logic              dep_inc_i,
  input  logic              dep_dec_i,
  output logic [ADDR_W-1:0] sp_nxt_o,
  output logic [ADDR_W-1:0] sp_prv_o,
  output logic [ADDR_W:0]   depth_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int              CAP     = (1 << ADDR_W) + 1;
  localparam logic [ADDR_W:0] CAP_V   = (ADDR_W+1)'(CAP);
  localparam logic [ADDR_W:0] DEP_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W:0]   depth_q, depth_d;

  assign sp_nxt_o = sp_q + SP_ONE;
  assign sp_prv_o = sp_q - SP_ONE;
  assign depth_o  = depth_q;
  assign empty_o  = (depth_q == '0);
  assign full_o   = (depth_q == CAP_V);

  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (sp_inc_i)      sp_d = sp_nxt_o;
    else if (sp_dec_i) sp_d = sp_prv_o;
    if (dep_inc_i)      depth_d = depth_q + DEP_ONE;
    else if (dep_dec_i) depth_d = depth_q - DEP_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/stack_tos_cache.sv
// Forth stack with TOS in a register and NOS from a synchronous-read RAM; one op per cycle.
// Tracks depth, full/empty, and sticky overflow/underflow flags.
module stack_tos_cache
  import stack_tos_cache_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WIDTH    = 16,
  parameter bit OVF_MODE = OVF_WRAP
) (
  input  logic               clk,
  input  logic               reset_n,
  stack_tos_cache_if.slave   bus
);
  localparam logic [ADDR_W:0] DEP_ONE = (ADDR_W+1)'(1);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rd_q;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic             nos_src_q, nos_src_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [ADDR_W-1:0] sp_nxt, sp_prv;
  logic [ADDR_W:0]   depth;
  logic              empty, full;
  logic              sp_inc, sp_dec, dep_inc, dep_dec;
  logic              ram_we, ram_re, ovf_set, unf_set;
  logic [WIDTH-1:0]  nos_cur;
  op_e               op;

  stack_tos_cache_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .sp_inc_i  (sp_inc),
    .sp_dec_i  (sp_dec),
    .dep_inc_i (dep_inc),
    .dep_dec_i (dep_dec),
    .sp_nxt_o  (sp_nxt),
    .sp_prv_o  (sp_prv),
    .depth_o   (depth),
    .empty_o   (empty),
    .full_o    (full)
  );

  assign op      = decode_op(bus.push, bus.pop, bus.wr_tos);
  // nos is either the forwarded old TOS (after a push) or the last RAM read (after a pop).
  assign nos_cur = nos_src_q ? rd_q : nos_q;

  always_comb begin
    tos_d     = tos_q;
    nos_d     = nos_q;
    nos_src_d = nos_src_q;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    dep_inc   = 1'b0;
    dep_dec   = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (op)
      OP_REPL: begin
        tos_d   = bus.d;
        dep_inc = empty;
      end
      OP_PUSH: begin
        if (full) ovf_set = 1'b1;
        if (empty) begin
          tos_d   = bus.d;
          dep_inc = 1'b1;
        end else if (!full || OVF_MODE == OVF_WRAP) begin
          // In wrap mode the slot after sp holds the oldest entry, so it is simply overwritten.
          ram_we    = 1'b1;
          tos_d     = bus.d;
          nos_d     = tos_q;
          nos_src_d = 1'b0;
          sp_inc    = 1'b1;
          dep_inc   = !full;
        end
      end
      OP_POPWR, OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          dep_dec = 1'b1;
          if (depth == DEP_ONE) begin
            tos_d = '0;
          end else begin
            tos_d     = (op == OP_POPWR) ? bus.d : nos_cur;
            sp_dec    = 1'b1;
            ram_re    = 1'b1;
            nos_src_d = 1'b1;
          end
        end
      end
      OP_WR:   tos_d = bus.d;
      default: ;
    endcase
    ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
    unf_d = unf_set | (unf_q & ~bus.err_clr);
  end

  // Push and pop never share a cycle here, so no read-during-write hazard reaches the RAM.
  always_ff @(posedge clk) begin
    if (ram_we) mem[sp_nxt] <= tos_q;
    if (ram_re) rd_q <= mem[sp_prv];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tos_q     <= '0;
      nos_q     <= '0;
      nos_src_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      tos_q     <= tos_d;
      nos_q     <= nos_d;
      nos_src_q <= nos_src_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.tos       = tos_q;
  assign bus.nos       = nos_cur;
  assign bus.depth     = depth;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_stack_tos_cache.sv
// Bench for stack_tos_cache: wrap and reject instances (ADDR_W=2) driven in lockstep against a stack model.
module tb_stack_tos_cache;
  import stack_tos_cache_pkg::*;

  localparam int AW  = 2;
  localparam int W   = 16;
  localparam int CAP = 5;

  typedef struct {
    logic [W-1:0] tos;
    logic [W-1:0] nos;
    logic [AW:0]  depth;
    logic         empty;
    logic         full;
    logic         ovf;
    logic         unf;
    bit           chk_nos;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stack_tos_cache_if #(.WIDTH(W), .ADDR_W(AW)) bw ();
  stack_tos_cache_if #(.WIDTH(W), .ADDR_W(AW)) br ();

  stack_tos_cache #(.ADDR_W(AW), .WIDTH(W), .OVF_MODE(OVF_WRAP)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(bw));
  stack_tos_cache #(.ADDR_W(AW), .WIDTH(W), .OVF_MODE(OVF_REJECT)) dut_r (
    .clk(clk), .reset_n(reset_n), .bus(br));

  logic [W-1:0] stk [2][CAP];
  int           cnt [2];
  bit           m_ovf [2];
  bit           m_unf [2];
  exp_t         exp_w_q [$];
  exp_t         exp_r_q [$];
  int           nerr = 0;
  int           nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit ps, input bit pp, input bit wr, input logic [W-1:0] dd, input bit clr);
    bw.push = ps; bw.pop = pp; bw.wr_tos = wr; bw.d = dd; bw.err_clr = clr;
    br.push = ps; br.pop = pp; br.wr_tos = wr; br.d = dd; br.err_clr = clr;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
    end
  endtask

  // m=0 models wrap-on-overflow, m=1 models reject-on-overflow.
  task automatic model_op(input int m, input bit ps, input bit pp, input bit wr,
                          input logic [W-1:0] dd, input bit clr);
    bit os = 0;
    bit us = 0;
    if (ps && pp) begin
      if (cnt[m] == 0) begin stk[m][0] = dd; cnt[m] = 1; end
      else stk[m][cnt[m]-1] = dd;
    end else if (ps) begin
      if (cnt[m] == CAP) begin
        os = 1;
        if (m == 0) begin
          for (int i = 0; i < CAP-1; i++) stk[m][i] = stk[m][i+1];
          stk[m][CAP-1] = dd;
        end
      end else begin
        stk[m][cnt[m]] = dd;
        cnt[m]++;
      end
    end else if (pp) begin
      if (cnt[m] == 0) us = 1;
      else begin
        cnt[m]--;
        if (wr && cnt[m] > 0) stk[m][cnt[m]-1] = dd;
      end
    end else if (wr && cnt[m] > 0) begin
      stk[m][cnt[m]-1] = dd;
    end
    m_ovf[m] = os ? 1'b1 : (clr ? 1'b0 : m_ovf[m]);
    m_unf[m] = us ? 1'b1 : (clr ? 1'b0 : m_unf[m]);
  endtask

  function automatic exp_t model_exp(input int m);
    exp_t e;
    e.tos     = (cnt[m] > 0) ? stk[m][cnt[m]-1] : '0;
    e.chk_nos = (cnt[m] >= 2);
    e.nos     = e.chk_nos ? stk[m][cnt[m]-2] : '0;
    e.depth   = (AW+1)'(cnt[m]);
    e.empty   = (cnt[m] == 0);
    e.full    = (cnt[m] == CAP);
    e.ovf     = m_ovf[m];
    e.unf     = m_unf[m];
    return e;
  endfunction

  task automatic cmp_dut(input int m, input exp_t e);
    string p;
    logic [W-1:0] o_tos, o_nos;
    logic [AW:0]  o_dep;
    logic o_e, o_f, o_o, o_u;
    if (m == 0) begin
      p = "wrap"; o_tos = bw.tos; o_nos = bw.nos; o_dep = bw.depth;
      o_e = bw.empty; o_f = bw.full; o_o = bw.overflow; o_u = bw.underflow;
    end else begin
      p = "rej"; o_tos = br.tos; o_nos = br.nos; o_dep = br.depth;
      o_e = br.empty; o_f = br.full; o_o = br.overflow; o_u = br.underflow;
    end
    chk({p, ".tos"}, o_tos, e.tos);
    if (e.chk_nos) chk({p, ".nos"}, o_nos, e.nos);
    chk({p, ".depth"}, o_dep, e.depth);
    chk({p, ".empty"}, o_e, e.empty);
    chk({p, ".full"}, o_f, e.full);
    chk({p, ".overflow"}, o_o, e.ovf);
    chk({p, ".underflow"}, o_u, e.unf);
  endtask

  task automatic step(input bit ps, input bit pp, input bit wr, input logic [W-1:0] dd, input bit clr);
    exp_t e;
    drive(ps, pp, wr, dd, clr);
    for (int m = 0; m < 2; m++) begin
      model_op(m, ps, pp, wr, dd, clr);
      e = model_exp(m);
      if (m == 0) exp_w_q.push_back(e);
      else        exp_r_q.push_back(e);
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, '0, 0);
    e = exp_w_q.pop_front();
    cmp_dut(0, e);
    e = exp_r_q.pop_front();
    cmp_dut(1, e);
  endtask

  initial begin
    exp_t z;
    drive(0, 0, 0, '0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    z = model_exp(0);
    z.chk_nos = 1;
    cmp_dut(0, z);
    cmp_dut(1, z);
    reset_n = 1'b1;

    // Basic push/pop
    step(1, 0, 0, 16'h1111, 0);
    step(1, 0, 0, 16'h2222, 0);
    step(1, 0, 0, 16'h3333, 0);
    chk("t2.tos", bw.tos, 16'h3333);
    chk("t2.nos", bw.nos, 16'h2222);
    chk("t2.depth", bw.depth, 3);
    step(0, 1, 0, '0, 0);
    chk("t2.pop.tos", bw.tos, 16'h2222);
    chk("t2.pop.nos", bw.nos, 16'h1111);
    chk("t2.pop.depth", bw.depth, 2);

    // Binary-op collapse then pop to empty
    step(0, 1, 1, 16'h00AA, 0);
    chk("t3.tos", bw.tos, 16'h00AA);
    chk("t3.depth", bw.depth, 1);
    step(0, 1, 0, '0, 0);
    chk("t3.empty", bw.empty, 1);
    chk("t3.tos0", bw.tos, 0);

    // Underflow, replace while empty, plain wr_tos
    step(0, 1, 0, '0, 0);
    chk("t6.underflow", bw.underflow, 1);
    chk("t6.depth", bw.depth, 0);
    step(1, 1, 0, 16'h0007, 0);
    chk("t6.repl.tos", bw.tos, 16'h0007);
    chk("t6.repl.depth", bw.depth, 1);
    step(0, 0, 1, 16'h0055, 0);
    chk("wr.tos", br.tos, 16'h0055);

    // Asynchronous reset in the middle of a push
    drive(1, 0, 0, 16'hBEEF, 0);
    #3 reset_n = 1'b0;
    #1;
    chk("arst.tos", bw.tos, 0);
    chk("arst.depth", bw.depth, 0);
    chk("arst.empty", br.empty, 1);
    chk("arst.underflow", bw.underflow, 0);
    #2 reset_n = 1'b1;
    model_reset();
    step(1, 0, 0, 16'hBEEF, 0);
    chk("arst.first.depth", bw.depth, 1);
    chk("arst.first.tos", bw.tos, 16'hBEEF);

    // Flag set beats err_clr in the same cycle
    step(0, 1, 0, '0, 0);
    step(0, 1, 0, '0, 1);
    chk("prio.underflow", bw.underflow, 1);
    step(0, 0, 0, '0, 1);
    chk("clr.underflow", bw.underflow, 0);

    // Overflow in both modes
    for (int i = 1; i <= 6; i++) step(1, 0, 0, W'(i), 0);
    chk("t4.overflow", bw.overflow, 1);
    chk("t4.depth", bw.depth, 5);
    chk("t4.tos", bw.tos, 6);
    chk("t4.nos", bw.nos, 5);
    chk("t5.overflow", br.overflow, 1);
    chk("t5.tos", br.tos, 5);
    chk("t5.full", br.full, 1);
    step(0, 0, 0, '0, 1);
    chk("t5.clr", br.overflow, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, 0);
    chk("t4.pops.tos", bw.tos, 2);
    chk("t5.pops.tos", br.tos, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
